// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: accepts up to PushWidth sequential instructions per cycle
// and presents them one at a time through a registered output stage with stall and flush.
module fetch_decode_queue #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned Depth                   = 8,
  parameter int unsigned PushWidth               = 2
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic                                   enable_i,
  input  logic [$clog2(PushWidth+1)-1:0]         pushCount_i,
  input  logic [PushWidth*instructionWidth-1:0]  instruction_i,
  input  logic [addressWidth-1:0]                instructionAddress_i,
  input  logic [instructionCounterWidth-1:0]     instructionMajId_i,
  input  logic                                   is64Bit_i,
  input  logic                                   stall_i,
  input  logic                                   flush_i,
  output logic                                   enable_o,
  output logic [instructionWidth-1:0]            instruction_o,
  output logic [addressWidth-1:0]                instructionAddress_o,
  output logic [instructionCounterWidth-1:0]     instructionMajId_o,
  output logic                                   is64Bit_o,
  output logic [$clog2(Depth+1)-1:0]             freeSlots_o,
  output logic                                   full_o,
  output logic                                   overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam int unsigned PcW  = $clog2(PushWidth+1);

  logic [instructionWidth-1:0]        instrMem [Depth];
  logic [addressWidth-1:0]            addrMem  [Depth];
  logic [instructionCounterWidth-1:0] idMem    [Depth];
  logic                               modeMem  [Depth];

  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] countNext;
  logic [CntW-1:0] pushLanes;
  logic            pushValid;
  logic            canLoad;
  logic            pop;

  // Acceptance is judged against the registered free count, so a same-cycle pop never widens it.
  always_comb begin
    pushValid = enable_i && !flush_i && (pushCount_i != '0)
                && (pushCount_i <= PcW'(PushWidth))
                && (CntW'(pushCount_i) <= freeSlots_o);
    canLoad   = !stall_i || !enable_o;
    pop       = !flush_i && (count != '0) && canLoad;
    pushLanes = pushValid ? CntW'(pushCount_i) : '0;
    countNext = count + pushLanes - CntW'(pop);
  end

  // Entry storage; lane k gets sequential address and ID offsets.
  always_ff @(posedge clock_i) begin
    if (pushValid) begin
      for (int k = 0; k < int'(PushWidth); k++) begin
        if (PcW'(k) < pushCount_i) begin
          instrMem[tailPtr + PtrW'(k)] <= instruction_i[k*instructionWidth +: instructionWidth];
          addrMem[tailPtr + PtrW'(k)]  <= instructionAddress_i + addressWidth'(4 * k);
          idMem[tailPtr + PtrW'(k)]    <= instructionMajId_i + instructionCounterWidth'(k);
          modeMem[tailPtr + PtrW'(k)]  <= is64Bit_i;
        end
      end
    end
  end

  // Pointers, occupancy and the output register stage.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      headPtr              <= '0;
      tailPtr              <= '0;
      count                <= '0;
      freeSlots_o          <= CntW'(Depth);
      full_o               <= 1'b0;
      overflow_o           <= 1'b0;
      enable_o             <= 1'b0;
      instruction_o        <= '0;
      instructionAddress_o <= '0;
      instructionMajId_o   <= '0;
      is64Bit_o            <= 1'b0;
    end else if (flush_i) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      freeSlots_o <= CntW'(Depth);
      full_o      <= 1'b0;
      overflow_o  <= 1'b0;
      enable_o    <= 1'b0;
    end else begin
      overflow_o  <= enable_i && !pushValid;
      count       <= countNext;
      freeSlots_o <= CntW'(Depth) - countNext;
      full_o      <= (countNext == CntW'(Depth));
      if (pushValid) begin
        tailPtr <= tailPtr + PtrW'(pushCount_i);
      end
      if (pop) begin
        headPtr              <= headPtr + PtrW'(1);
        enable_o             <= 1'b1;
        instruction_o        <= instrMem[headPtr];
        instructionAddress_o <= addrMem[headPtr];
        instructionMajId_o   <= idMem[headPtr];
        is64Bit_o            <= modeMem[headPtr];
      end else if (canLoad) begin
        enable_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_decode_queue;

  localparam int unsigned AW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW    = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 2;
  localparam int unsigned PCW   = $clog2(PW+1);
  localparam int unsigned FSW   = $clog2(DEPTH+1);

  logic             clock_i;
  logic             reset_i;
  logic             enable_i;
  logic [PCW-1:0]   pushCount_i;
  logic [PW*IW-1:0] instruction_i;
  logic [AW-1:0]    instructionAddress_i;
  logic [CW-1:0]    instructionMajId_i;
  logic             is64Bit_i;
  logic             stall_i;
  logic             flush_i;
  logic             enable_o;
  logic [IW-1:0]    instruction_o;
  logic [AW-1:0]    instructionAddress_o;
  logic [CW-1:0]    instructionMajId_o;
  logic             is64Bit_o;
  logic [FSW-1:0]   freeSlots_o;
  logic             full_o;
  logic             overflow_o;

  fetch_decode_queue #(
    .addressWidth(AW), .instructionWidth(IW), .instructionCounterWidth(CW),
    .Depth(DEPTH), .PushWidth(PW)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .pushCount_i(pushCount_i),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .instructionMajId_i(instructionMajId_i), .is64Bit_i(is64Bit_i), .stall_i(stall_i),
    .flush_i(flush_i), .enable_o(enable_o), .instruction_o(instruction_o),
    .instructionAddress_o(instructionAddress_o), .instructionMajId_o(instructionMajId_o),
    .is64Bit_o(is64Bit_o), .freeSlots_o(freeSlots_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [IW-1:0] ins;
    logic [AW-1:0] addr;
    logic [CW-1:0] id;
    logic          m;
  } entry_t;

  entry_t        mq[$];
  entry_t        mOut;
  bit            mValid;
  bit            mOvf;
  int            tests;
  int            fails;
  bit            recording;
  logic [CW-1:0] seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    chk("enable", 64'(enable_o), 64'(mValid));
    chk("freeSlots", 64'(freeSlots_o), 64'(int'(DEPTH) - mq.size()));
    chk("full", 64'(full_o), 64'(mq.size() == int'(DEPTH)));
    chk("overflow", 64'(overflow_o), 64'(mOvf));
    if (mValid) begin
      chk("instr", 64'(instruction_o), 64'(mOut.ins));
      chk("addr", instructionAddress_o, mOut.addr);
      chk("majId", instructionMajId_o, mOut.id);
      chk("is64", 64'(is64Bit_o), 64'(mOut.m));
    end
    if (recording && enable_o) seen.push_back(instructionMajId_o);
  endtask

  // Next-state of the model from the inputs currently applied.
  task automatic modelStep();
    int     free;
    bit     acc;
    bit     mayLoad;
    entry_t e;
    free = int'(DEPTH) - mq.size();
    if (flush_i) begin
      mq.delete();
      mValid = 0;
      mOvf   = 0;
    end else begin
      acc = enable_i && (int'(pushCount_i) >= 1) && (int'(pushCount_i) <= int'(PW))
            && (int'(pushCount_i) <= free);
      mayLoad = !stall_i || !mValid;
      if (mayLoad && mq.size() > 0) begin
        mOut   = mq.pop_front();
        mValid = 1;
      end else if (mayLoad) begin
        mValid = 0;
      end
      if (acc) begin
        for (int k = 0; k < int'(pushCount_i); k++) begin
          e.ins  = instruction_i[k*IW +: IW];
          e.addr = instructionAddress_i + AW'(4 * k);
          e.id   = instructionMajId_i + CW'(k);
          e.m    = is64Bit_i;
          mq.push_back(e);
        end
      end
      mOvf = enable_i && !acc;
    end
  endtask

  task automatic resetModel();
    mq.delete();
    mValid    = 0;
    mOvf      = 0;
    mOut.ins  = '0;
    mOut.addr = '0;
    mOut.id   = '0;
    mOut.m    = 1'b0;
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clock_i);
    @(negedge clock_i);
    checkModel();
  endtask

  task automatic setIn(input bit en, input int pc, input logic [63:0] addr, input logic [63:0] id,
                       input logic [31:0] w0, input logic [31:0] w1, input bit st, input bit fl);
    enable_i             = en;
    pushCount_i          = PCW'(pc);
    instructionAddress_i = addr;
    instructionMajId_i   = id;
    instruction_i        = {w1, w0};
    is64Bit_i            = addr[3];
    stall_i              = st;
    flush_i              = fl;
  endtask

  task automatic idle(input bit st);
    setIn(0, 0, 64'h0, 64'h0, 32'h0, 32'h0, st, 0);
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_enable"}, 64'(enable_o), 64'd0);
    chk({tag, "_full"}, 64'(full_o), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    chk({tag, "_freeSlots"}, 64'(freeSlots_o), 64'd8);
    chk({tag, "_instr"}, 64'(instruction_o), 64'd0);
    chk({tag, "_addr"}, instructionAddress_o, 64'd0);
    chk({tag, "_majId"}, instructionMajId_o, 64'd0);
    chk({tag, "_is64"}, 64'(is64Bit_o), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    recording = 0;
    reset_i = 1'b0;
    idle(0);
    resetModel();
    repeat (2) @(negedge clock_i);
    checkResetVals("por");
    reset_i = 1'b1;

    // Two-lane push into an empty queue
    setIn(1, 2, 64'h1000, 64'd5, 32'hAAAA0000, 32'hBBBB0000, 0, 0);
    cycle();
    chk("lat_edge1_enable", 64'(enable_o), 64'd0);
    idle(0);
    cycle();
    chk("single_l0_enable", 64'(enable_o), 64'd1);
    chk("single_l0_addr", instructionAddress_o, 64'h1000);
    chk("single_l0_id", instructionMajId_o, 64'd5);
    chk("single_l0_instr", 64'(instruction_o), 64'hAAAA0000);
    cycle();
    chk("single_l1_addr", instructionAddress_o, 64'h1004);
    chk("single_l1_id", instructionMajId_o, 64'd6);
    chk("single_l1_instr", 64'(instruction_o), 64'hBBBB0000);
    cycle();
    chk("single_drain_enable", 64'(enable_o), 64'd0);

    // Fill under stall: 9 lanes accepted in total, then overflow
    for (int i = 0; i < 4; i++) begin
      setIn(1, 2, 64'h2000 + 64'(8 * i), 64'(100 + 2 * i), 32'h1100 + 32'(i), 32'h2200 + 32'(i), 1, 0);
      cycle();
    end
    chk("fill_free_after8", 64'(freeSlots_o), 64'd1);
    setIn(1, 1, 64'h2020, 64'd108, 32'h3300, 32'h0, 1, 0);
    cycle();
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_free0", 64'(freeSlots_o), 64'd0);
    setIn(1, 1, 64'h2024, 64'd109, 32'h4400, 32'h0, 1, 0);
    cycle();
    chk("fill_overflow", 64'(overflow_o), 64'd1);
    chk("fill_head_held", 64'(instruction_o), 64'h1100);
    chk("fill_head_id", instructionMajId_o, 64'd100);
    idle(1);
    cycle();
    chk("fill_overflow_pulse", 64'(overflow_o), 64'd0);
    setIn(0, 0, 64'h0, 64'h0, 32'h0, 32'h0, 1, 1);
    cycle();
    chk("flush_stall_enable", 64'(enable_o), 64'd0);
    chk("flush_stall_free", 64'(freeSlots_o), 64'd8);

    // Flush with a simultaneous push
    setIn(1, 2, 64'h5000, 64'd40, 32'h5000, 32'h5001, 1, 0);
    cycle();
    setIn(1, 2, 64'h5008, 64'd42, 32'h5002, 32'h5003, 1, 0);
    cycle();
    chk("fp_free5", 64'(freeSlots_o), 64'd5);
    setIn(1, 2, 64'hDEAD0000, 64'hDEAD, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
    cycle();
    chk("fp_enable", 64'(enable_o), 64'd0);
    chk("fp_free", 64'(freeSlots_o), 64'd8);
    idle(0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("fp_never_appears", 64'(enable_o), 64'd0);
    end

    // Wrap-around with continuous pops
    recording = 1;
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      setIn(1, 1, 64'h3000 + 64'(4 * i), 64'(i), 32'h7000 + 32'(i), 32'h0, 0, 0);
      cycle();
    end
    idle(0);
    repeat (3) cycle();
    recording = 0;
    chk("wrap_count", 64'(seen.size()), 64'd20);
    for (int i = 0; i < 20 && i < seen.size(); i++) chk("wrap_id", seen[i], 64'(i));

    // Asynchronous reset between edges with 5 entries queued
    for (int i = 0; i < 3; i++) begin
      setIn(1, 2, 64'h6000 + 64'(8 * i), 64'(200 + 2 * i), 32'h6600 + 32'(i), 32'h6700 + 32'(i), 1, 0);
      cycle();
    end
    chk("ar_free3", 64'(freeSlots_o), 64'd3);
    idle(1);
    #2 reset_i = 1'b0;
    #1 checkResetVals("async");
    resetModel();
    @(posedge clock_i);
    @(negedge clock_i);
    checkResetVals("held");
    reset_i = 1'b1;
    setIn(1, 1, 64'h4000, 64'd77, 32'h12345678, 32'h0, 0, 0);
    cycle();
    chk("ar_edge1_enable", 64'(enable_o), 64'd0);
    idle(0);
    cycle();
    chk("ar_edge2_enable", 64'(enable_o), 64'd1);
    chk("ar_edge2_id", instructionMajId_o, 64'd77);
    chk("ar_edge2_instr", 64'(instruction_o), 64'h12345678);

    // Randomized traffic, including IDs/addresses near the wrap point
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] a;
      logic [63:0] id;
      a  = {$urandom, $urandom};
      id = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2)))
                                       : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFC;
      setIn($urandom_range(0, 9) < 6, $urandom_range(0, 3), a, id, $urandom, $urandom,
            $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
